mask_unit_read_xbar_rr: RTL and testbench

- Parametrised, registered successor to the mask-unit read crossbar. Routes read requests from NUM_IN requesters to NUM_LANE lane read ports.
- Each request's readLane selects its destination lane. Each lane has a round-robin arbiter and a 2-entry output buffer, so no requester can starve.
- Sits between the mask unit's read-request generators and the per-lane VRF read ports. Output writeIndex tags the source requester for the data-return path.

---
 rtl/mask_xbar_pkg.sv | 30 +++
 rtl/mask_xbar_lane.sv | 99 +++++++++
 rtl/mask_unit_read_xbar_rr.sv | 85 ++++++++
 tb/tb_mask_unit_read_xbar_rr.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_xbar_pkg.sv
// Shared types, default widths and helpers for the mask-unit read crossbar.
// Default field layout of a request and of a lane output entry.
package mask_xbar_pkg;

    localparam int unsigned NUM_IN_DEF   = 4;
    localparam int unsigned NUM_LANE_DEF = 4;
    localparam int unsigned VS_W_DEF     = 5;
    localparam int unsigned OFFSET_W_DEF = 9;
    localparam int unsigned DOFF_W_DEF   = 2;
    localparam int unsigned WIDX_W_DEF   = $clog2(NUM_IN_DEF);
    localparam int unsigned LANE_W_DEF   = $clog2(NUM_LANE_DEF);

    typedef struct packed {
        logic [VS_W_DEF-1:0]     vs;
        logic [OFFSET_W_DEF-1:0] offset;
        logic [DOFF_W_DEF-1:0]   dataOffset;
    } readReq_t;

    typedef struct packed {
        logic [VS_W_DEF-1:0]     vs;
        logic [OFFSET_W_DEF-1:0] offset;
        logic [WIDX_W_DEF-1:0]   writeIndex;
        logic [DOFF_W_DEF-1:0]   dataOffset;
    } readOut_t;

    function automatic logic [15:0] satInc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mask_xbar_lane.sv
// One crossbar lane: round-robin arbiter over requesters, 2-entry output FIFO,
// optional saturating conflict counter (MASK_XBAR_PERF_EN).
module mask_xbar_lane
    import mask_xbar_pkg::*;
#(
    parameter int NUM_IN   = NUM_IN_DEF,
    parameter int VS_W     = VS_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF,
    parameter int DOFF_W   = DOFF_W_DEF,
    parameter int WIDX_W   = $clog2(NUM_IN)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_IN-1:0]          cand,
    input  logic [NUM_IN*VS_W-1:0]     reqVs,
    input  logic [NUM_IN*OFFSET_W-1:0] reqOffset,
    input  logic [NUM_IN*DOFF_W-1:0]   reqDataOffset,
    input  logic                       outReady,
    output logic [NUM_IN-1:0]          grant,
    output logic                       outValid,
    output logic [VS_W-1:0]            outVs,
    output logic [OFFSET_W-1:0]        outOffset,
    output logic [WIDX_W-1:0]          outWriteIndex,
    output logic [DOFF_W-1:0]          outDataOffset
`ifdef MASK_XBAR_PERF_EN
    ,
    output logic [15:0]                conflictCnt
`endif
);

    localparam int ENTRY_W = VS_W + OFFSET_W + WIDX_W + DOFF_W;

    logic [WIDX_W-1:0]  ptr, winner, idx;
    logic               found, canAccept, push, pop;
    logic [1:0]         count;
    logic               rdPtr, wrPtr;
    logic [ENTRY_W-1:0] mem [2];
    logic [ENTRY_W-1:0] newEntry;

    // First candidate at or after the pointer, wrapping at NUM_IN.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = WIDX_W'((int'(ptr) + k) % NUM_IN);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign canAccept = (count != 2'd2) || outReady;
    assign push      = found && canAccept;
    assign pop       = (count != 2'd0) && outReady;
    assign grant     = push ? (NUM_IN'(1) << winner) : '0;
    assign newEntry  = {reqVs[winner*VS_W +: VS_W], reqOffset[winner*OFFSET_W +: OFFSET_W],
                        winner, reqDataOffset[winner*DOFF_W +: DOFF_W]};

    assign outValid = (count != 2'd0);
    assign {outVs, outOffset, outWriteIndex, outDataOffset} = mem[rdPtr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rdPtr  <= 1'b0;
            wrPtr  <= 1'b0;
            count  <= 2'd0;
            ptr    <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= newEntry;
                wrPtr      <= ~wrPtr;
                ptr        <= (winner == WIDX_W'(NUM_IN - 1)) ? '0 : winner + 1'b1;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef MASK_XBAR_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conflictCnt <= 16'd0;
        end else if (($countones(cand) >= 2) || (found && !canAccept)) begin
            conflictCnt <= satInc16(conflictCnt);
        end
    end
`endif

endmodule

// File: rtl/mask_unit_read_xbar_rr.sv
// Registered mask-unit read crossbar: NUM_IN requesters to NUM_LANE lanes with
// per-lane round-robin and 2-entry buffers. MASK_XBAR_PERF_EN adds conflict_cnt.
module mask_unit_read_xbar_rr
    import mask_xbar_pkg::*;
#(
    parameter int NUM_IN   = NUM_IN_DEF,
    parameter int NUM_LANE = NUM_LANE_DEF,
    parameter int VS_W     = VS_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF,
    parameter int DOFF_W   = DOFF_W_DEF
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_IN-1:0]                    in_valid,
    output logic [NUM_IN-1:0]                    in_ready,
    input  logic [NUM_IN*VS_W-1:0]               in_vs,
    input  logic [NUM_IN*OFFSET_W-1:0]           in_offset,
    input  logic [NUM_IN*$clog2(NUM_LANE)-1:0]   in_readLane,
    input  logic [NUM_IN*DOFF_W-1:0]             in_dataOffset,
    output logic [NUM_LANE-1:0]                  out_valid,
    input  logic [NUM_LANE-1:0]                  out_ready,
    output logic [NUM_LANE*VS_W-1:0]             out_vs,
    output logic [NUM_LANE*OFFSET_W-1:0]         out_offset,
    output logic [NUM_LANE*$clog2(NUM_IN)-1:0]   out_writeIndex,
    output logic [NUM_LANE*DOFF_W-1:0]           out_dataOffset
`ifdef MASK_XBAR_PERF_EN
    ,
    output logic [NUM_LANE*16-1:0]               conflict_cnt
`endif
);

    localparam int LANE_W = $clog2(NUM_LANE);
    localparam int WIDX_W = $clog2(NUM_IN);

    logic [NUM_IN-1:0] laneCand  [NUM_LANE];
    logic [NUM_IN-1:0] laneGrant [NUM_LANE];
    logic [NUM_IN-1:0] readyAll;

    always_comb begin
        laneCand = '{default: '0};
        for (int l = 0; l < NUM_LANE; l++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                laneCand[l][i] = in_valid[i] && (in_readLane[i*LANE_W +: LANE_W] == LANE_W'(l));
            end
        end
    end

    // Each requester targets one lane, so at most one lane can grant it.
    always_comb begin
        readyAll = '0;
        for (int l = 0; l < NUM_LANE; l++) begin
            readyAll = readyAll | laneGrant[l];
        end
        in_ready = readyAll & {NUM_IN{reset}};
    end

    for (genvar l = 0; l < NUM_LANE; l++) begin : gLane
        mask_xbar_lane #(
            .NUM_IN   (NUM_IN),
            .VS_W     (VS_W),
            .OFFSET_W (OFFSET_W),
            .DOFF_W   (DOFF_W),
            .WIDX_W   (WIDX_W)
        ) uLane (
            .clock         (clock),
            .reset         (reset),
            .cand          (laneCand[l]),
            .reqVs         (in_vs),
            .reqOffset     (in_offset),
            .reqDataOffset (in_dataOffset),
            .outReady      (out_ready[l]),
            .grant         (laneGrant[l]),
            .outValid      (out_valid[l]),
            .outVs         (out_vs[l*VS_W +: VS_W]),
            .outOffset     (out_offset[l*OFFSET_W +: OFFSET_W]),
            .outWriteIndex (out_writeIndex[l*WIDX_W +: WIDX_W]),
            .outDataOffset (out_dataOffset[l*DOFF_W +: DOFF_W])
`ifdef MASK_XBAR_PERF_EN
            ,
            .conflictCnt   (conflict_cnt[l*16 +: 16])
`endif
        );
    end

endmodule

// File: tb/tb_mask_unit_read_xbar_rr.sv
// Self-checking bench for mask_unit_read_xbar_rr against a queue-based lane model.
module tb_mask_unit_read_xbar_rr;

    localparam int NI = 4;
    localparam int NL = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  in_valid, in_ready;
    logic [19:0] in_vs;
    logic [35:0] in_offset;
    logic [7:0]  in_readLane, in_dataOffset;
    logic [3:0]  out_valid, out_ready;
    logic [19:0] out_vs;
    logic [35:0] out_offset;
    logic [7:0]  out_writeIndex, out_dataOffset;
`ifdef MASK_XBAR_PERF_EN
    logic [63:0] conflict_cnt;
`endif

    mask_unit_read_xbar_rr dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_vs(in_vs), .in_offset(in_offset),
        .in_readLane(in_readLane), .in_dataOffset(in_dataOffset),
        .out_valid(out_valid), .out_ready(out_ready), .out_vs(out_vs), .out_offset(out_offset),
        .out_writeIndex(out_writeIndex), .out_dataOffset(out_dataOffset)
`ifdef MASK_XBAR_PERF_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0] vs;
        logic [8:0] off;
        logic [1:0] widx;
        logic [1:0] doff;
    } ent_t;

    ent_t        q [NL][$];
    int          rr [NL];
    logic [3:0]  expReady, expValid;
    logic [71:0] expHead, headMask;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [71:0] gotHeads();
        logic [71:0] h;
        for (int l = 0; l < NL; l++)
            h[l*18 +: 18] = {out_vs[l*5 +: 5], out_offset[l*9 +: 9],
                             out_writeIndex[l*2 +: 2], out_dataOffset[l*2 +: 2]};
        return h;
    endfunction

    // Expected handshake and lane heads for the current (stable) inputs.
    task automatic predict();
        @(negedge clock);
        expReady = '0; expValid = '0; expHead = '0; headMask = '0;
        for (int l = 0; l < NL; l++) begin
            int best = -1;
            for (int k = 0; k < NI; k++) begin
                int i = (rr[l] + k) % NI;
                if (best < 0 && in_valid[i] && int'(in_readLane[i*2 +: 2]) == l) best = i;
            end
            if (best >= 0 && (q[l].size() < 2 || out_ready[l])) expReady[best] = 1'b1;
            if (q[l].size() != 0) begin
                expValid[l] = 1'b1;
                expHead[l*18 +: 18] = q[l][0];
                headMask[l*18 +: 18] = '1;
            end
        end
    endtask

    task automatic advance();
        @(posedge clock);
        for (int l = 0; l < NL; l++)
            if (q[l].size() != 0 && out_ready[l]) void'(q[l].pop_front());
        for (int i = 0; i < NI; i++) begin
            if (expReady[i]) begin
                int l = int'(in_readLane[i*2 +: 2]);
                ent_t e;
                e.vs = in_vs[i*5 +: 5]; e.off = in_offset[i*9 +: 9];
                e.widx = 2'(i); e.doff = in_dataOffset[i*2 +: 2];
                q[l].push_back(e);
                rr[l] = (i + 1) % NI;
            end
        end
        #1;
    endtask

    task automatic modelReset();
        for (int l = 0; l < NL; l++) begin
            q[l].delete();
            rr[l] = 0;
        end
    endtask

    task automatic setReq(input int i, input logic v, input logic [1:0] lane,
                          input logic [4:0] vs, input logic [8:0] off, input logic [1:0] doff);
        in_valid[i] = v; in_readLane[i*2 +: 2] = lane;
        in_vs[i*5 +: 5] = vs; in_offset[i*9 +: 9] = off; in_dataOffset[i*2 +: 2] = doff;
    endtask

    task automatic drain();
        in_valid = '0; out_ready = '1;
        repeat (3) begin
            predict();
            checks++;
            if (out_valid !== expValid || (gotHeads() & headMask) !== expHead) begin
                errors++; $display("FAIL drain_out got %h/%h exp %h/%h", out_valid, gotHeads() & headMask, expValid, expHead);
            end
            advance();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 4'hF; in_readLane = 8'hE4; in_vs = '1; in_offset = '1;
        in_dataOffset = '1; out_ready = '1;
        modelReset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (in_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got %h exp 0", in_ready); end
        checks++;
        if (out_valid !== 4'h0) begin errors++; $display("FAIL reset_valid got %h exp 0", out_valid); end
        checks++;
        if (gotHeads() !== 72'h0) begin errors++; $display("FAIL reset_data got %h exp 0", gotHeads()); end
        @(posedge clock); #1;
        reset = 1'b1; in_valid = '0;
    endtask

    task automatic test_single();
        in_valid = '0; out_ready = '1;
        setReq(0, 1'b1, 2'd2, 5'h03, 9'h01A, 2'd1);
        predict();
        checks++;
        if (in_ready !== 4'b0001 || expReady !== 4'b0001) begin
            errors++; $display("FAIL single_ready got %b exp 0001", in_ready);
        end
        advance();
        in_valid = '0;
        predict();
        checks++;
        if (out_valid !== 4'b0100 || out_vs[14:10] !== 5'h03 || out_offset[26:18] !== 9'h01A
            || out_writeIndex[5:4] !== 2'd0) begin
            errors++; $display("FAIL single_out got v=%b vs=%h off=%h wi=%0d exp v=0100 vs=3 off=1a wi=0",
                               out_valid, out_vs[14:10], out_offset[26:18], out_writeIndex[5:4]);
        end
        advance();
    endtask

    task automatic test_conflict();
        drain();
        for (int i = 0; i < NI; i++) setReq(i, 1'b1, 2'd1, 5'(i + 8), 9'(i * 3), 2'(i));
        for (int k = 0; k < 6; k++) begin
            predict();
            checks++;
            if (in_ready !== (4'b0001 << (k % 4)) || in_ready !== expReady) begin
                errors++; $display("FAIL conflict_grant%0d got %b exp %b", k, in_ready, 4'b0001 << (k % 4));
            end
            if (k > 0) begin
                checks++;
                if (out_writeIndex[3:2] !== 2'((k - 1) % 4) || out_valid !== expValid) begin
                    errors++; $display("FAIL conflict_widx%0d got %0d exp %0d", k, out_writeIndex[3:2], (k - 1) % 4);
                end
            end
            advance();
        end
        in_valid = '0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat [8];
        pat = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        drain();
        out_ready = 4'b1110;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) out_ready = 4'b1111;
            setReq(0, 1'b1, 2'd0, 5'($urandom), 9'($urandom), 2'($urandom));
            predict();
            checks++;
            if (in_ready !== pat[k] || in_ready !== expReady) begin
                errors++; $display("FAIL bp_ready%0d got %b exp %b", k, in_ready, pat[k]);
            end
            checks++;
            if (out_valid !== expValid || (gotHeads() & headMask) !== expHead) begin
                errors++; $display("FAIL bp_out%0d got %h exp %h", k, gotHeads() & headMask, expHead);
            end
            advance();
        end
        drain();
    endtask

    task automatic test_disjoint();
        drain();
        for (int i = 0; i < NI; i++) setReq(i, 1'b1, 2'(3 - i), 5'($urandom), 9'($urandom), 2'($urandom));
        predict();
        checks++;
        if (in_ready !== 4'hF) begin errors++; $display("FAIL disjoint_ready got %h exp f", in_ready); end
        advance();
        in_valid = '0;
        predict();
        checks++;
        if (out_valid !== 4'hF || out_writeIndex !== 8'h1B || (gotHeads() & headMask) !== expHead) begin
            errors++; $display("FAIL disjoint_out got v=%h wi=%h exp v=f wi=1b", out_valid, out_writeIndex);
        end
        advance();
    endtask

    task automatic test_random();
        drain();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NI; i++)
                setReq(i, 1'($urandom_range(0, 3) != 0), 2'($urandom), 5'($urandom), 9'($urandom), 2'($urandom));
            out_ready = 4'($urandom);
            predict();
            checks++;
            if (in_ready !== expReady) begin
                errors++; $display("FAIL rand_ready%0d got %b exp %b", k, in_ready, expReady);
            end
            checks++;
            if (out_valid !== expValid || (gotHeads() & headMask) !== expHead) begin
                errors++; $display("FAIL rand_out%0d got %b/%h exp %b/%h", k, out_valid, gotHeads() & headMask, expValid, expHead);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        drain();
        out_ready = 4'b0111;
        setReq(0, 1'b1, 2'd3, 5'h11, 9'h022, 2'd3);
        repeat (2) begin predict(); advance(); end
        predict();
        checks++;
        if (out_valid[3] !== 1'b1 || q[3].size() != 2) begin
            errors++; $display("FAIL mid_fill got %b exp 1", out_valid[3]);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'h0 || in_ready !== 4'h0) begin
            errors++; $display("FAIL mid_async got v=%h r=%h exp 0/0", out_valid, in_ready);
        end
        modelReset();
        @(posedge clock); #1;
        reset = 1'b1;
        out_ready = '1;
        for (int i = 0; i < NI; i++) setReq(i, 1'b1, 2'd3, 5'(i), 9'(i), 2'(i));
        predict();
        checks++;
        if (in_ready !== 4'b0001 || in_ready !== expReady) begin
            errors++; $display("FAIL mid_first got %b exp 0001", in_ready);
        end
        advance();
        in_valid = '0;
    endtask

`ifdef MASK_XBAR_PERF_EN
    task automatic test_perf();
        in_valid = '0; out_ready = '1;
        reset = 1'b0; modelReset();
        @(posedge clock); #1 reset = 1'b1;
        checks++;
        if (conflict_cnt !== 64'h0) begin errors++; $display("FAIL perf_reset got %h exp 0", conflict_cnt); end
        setReq(0, 1'b1, 2'd0, 5'd1, 9'd1, 2'd0);
        setReq(1, 1'b1, 2'd0, 5'd2, 9'd2, 2'd0);
        repeat (10) @(posedge clock);
        #1 in_valid = '0;
        checks++;
        if (conflict_cnt !== {48'h0, 16'd10}) begin
            errors++; $display("FAIL perf_count got %h exp a", conflict_cnt);
        end
        in_valid = 4'b0011;
        repeat (65541) @(posedge clock);
        #1 in_valid = '0;
        checks++;
        if (conflict_cnt !== {48'h0, 16'hFFFF}) begin
            errors++; $display("FAIL perf_sat got %h exp ffff", conflict_cnt);
        end
    endtask
`endif

    initial begin
        in_valid = '0; in_vs = '0; in_offset = '0; in_readLane = '0; in_dataOffset = '0;
        out_ready = '0; reset = 1'b0;
        test_reset();
        test_single();
        test_conflict();
        test_back_to_back();
        test_disjoint();
        test_random();
        test_reset_mid();
`ifdef MASK_XBAR_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
